// File: rtl/freelist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freelist_ctrl_pkg
// Description : Shared sizes, types and FSM encoding for the freelist
//               sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package freelist_ctrl_pkg;

  localparam int NUM_PREGS         = 64;
  localparam int MAX_PREDICT_DEPTH = 4;
  localparam int PREG_W            = $clog2(NUM_PREGS);
  localparam int TAG_W             = $clog2(MAX_PREDICT_DEPTH + 1);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [TAG_W-1:0]  btag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOOT  = 2'd1,
    SETTLE = 2'd2
  } fsm_state_t;

  // Number of set bits in a 2-slot mask.
  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/freelist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : freelist_ctrl_if
// Description : Rename, freelist, branch-resolution and retire signals of
//               the freelist controller. The slave side is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface freelist_ctrl_if;
  import freelist_ctrl_pkg::*;

  // Rename group
  logic                ren_valid;
  logic                ren_ready;
  logic [1:0]          ren_need;
  logic [1:0]          ren_br;
  preg_t               ren_preg0;
  preg_t               ren_preg1;
  btag_t               ren_tag0;
  btag_t               ren_tag1;
  // Freelist
  logic [PREG_W:0]     fl_num_free;
  preg_t               fl_preg1;
  preg_t               fl_preg2;
  logic [1:0]          fl_alloc_cnt;
  btag_t               fl_tag1;
  btag_t               fl_tag2;
  logic                fl_shootdown;
  btag_t               fl_shoot_tag;
  logic                fl_free1;
  logic                fl_free2;
  preg_t               fl_free1_addr;
  preg_t               fl_free2_addr;
  // Branch resolution
  logic                mispredict_valid;
  btag_t               mispredict_tag;
  logic                br_commit;
  // Retire
  logic [1:0]          ret_valid;
  preg_t               ret_preg0;
  preg_t               ret_preg1;
  logic                ret_ready;
  // Status
  btag_t               depth;
  logic                busy;

  modport slave (
    input  ren_valid, ren_need, ren_br, fl_num_free, fl_preg1, fl_preg2,
           mispredict_valid, mispredict_tag, br_commit,
           ret_valid, ret_preg0, ret_preg1,
    output ren_ready, ren_preg0, ren_preg1, ren_tag0, ren_tag1,
           fl_alloc_cnt, fl_tag1, fl_tag2, fl_shootdown, fl_shoot_tag,
           fl_free1, fl_free2, fl_free1_addr, fl_free2_addr,
           ret_ready, depth, busy
  );

  modport master (
    output ren_valid, ren_need, ren_br, fl_num_free, fl_preg1, fl_preg2,
           mispredict_valid, mispredict_tag, br_commit,
           ret_valid, ret_preg0, ret_preg1,
    input  ren_ready, ren_preg0, ren_preg1, ren_tag0, ren_tag1,
           fl_alloc_cnt, fl_tag1, fl_tag2, fl_shootdown, fl_shoot_tag,
           fl_free1, fl_free2, fl_free1_addr, fl_free2_addr,
           ret_ready, depth, busy
  );

endinterface
`default_nettype wire

// File: rtl/freelist_ctrl_free_queue.sv
`default_nettype none
// ============================================================================
// Module      : freelist_ctrl_free_queue
// Description : 2-in / 2-out circular FIFO buffering retire-time frees.
//               Free strobes come from registered state only, so a pushed
//               entry is visible no earlier than the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module freelist_ctrl_free_queue
  import freelist_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [1:0] push_valid_i,
  input  wire preg_t      push_preg0_i,
  input  wire preg_t      push_preg1_i,
  output logic            push_ready_o,
  input  wire logic       pop_en_i,
  output logic            free1_o,
  output logic            free2_o,
  output preg_t           free1_addr_o,
  output preg_t           free2_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  preg_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              w_push0;
  logic              w_push1;
  logic [1:0]        w_npush;
  logic [1:0]        w_npop;

  // Handshake, push/pop counts and head-of-queue strobes.
  always_comb begin
    push_ready_o = (C_DEPTH - count_q) >= CNT_W'(2);
    w_push0      = push_ready_o & push_valid_i[0];
    w_push1      = push_ready_o & push_valid_i[1];
    w_npush      = {1'b0, w_push0} + {1'b0, w_push1};
    free1_o      = pop_en_i & (count_q >= CNT_W'(1));
    free2_o      = pop_en_i & (count_q >= CNT_W'(2));
    w_npop       = {1'b0, free1_o} + {1'b0, free2_o};
    free1_addr_o = free1_o ? mem_q[head_q] : '0;
    free2_addr_o = free2_o ? mem_q[head_q + PTR_W'(1)] : '0;
  end

  // Storage: slot 1 lands behind slot 0 only when slot 0 also pushed.
  always_ff @(posedge clk) begin
    if (w_push0) mem_q[tail_q] <= push_preg0_i;
    if (w_push1) mem_q[tail_q + PTR_W'(w_push0)] <= push_preg1_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(w_npush);
      head_q  <= head_q + PTR_W'(w_npop);
      count_q <= count_q + CNT_W'(w_npush) - CNT_W'(w_npop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/freelist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : freelist_ctrl
// Description : Sequencing controller in front of the physical-register
//               freelist: 2-wide rename allocation, branch tagging,
//               mispredict shootdown and buffered retire frees.
// Revision    : 1.0 - initial release
// ============================================================================
module freelist_ctrl
  import freelist_ctrl_pkg::*;
#(
  parameter int FREE_Q_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  freelist_ctrl_if.slave  bus
);

  fsm_state_t      state_q, state_d;
  btag_t           depth_q, depth_d;
  btag_t           shoot_tag_q, shoot_tag_d;

  logic [1:0]      w_nbr;
  logic [1:0]      w_nneed;
  logic [TAG_W:0]  w_depth_sum;
  logic            w_accept;
  logic            w_commit_dec;
  logic            w_restart;
  btag_t           w_tag0;
  btag_t           w_tag1;

  // Rename handshake and allocation mapping; everything zero when no accept.
  always_comb begin
    w_nbr        = popcnt2(bus.ren_br);
    w_nneed      = popcnt2(bus.ren_need);
    w_depth_sum  = {1'b0, depth_q} + (TAG_W+1)'(w_nbr);
    bus.ren_ready = (state_q == IDLE) & ~bus.mispredict_valid
                  & ((PREG_W+1)'(w_nneed) <= bus.fl_num_free)
                  & (w_depth_sum <= (TAG_W+1)'(MAX_PREDICT_DEPTH));
    w_accept     = bus.ren_valid & bus.ren_ready & ~reset;
    w_tag0       = depth_q;
    w_tag1       = depth_q + btag_t'(bus.ren_br[0]);

    bus.fl_alloc_cnt = '0;
    bus.ren_preg0    = '0;
    bus.ren_preg1    = '0;
    bus.ren_tag0     = '0;
    bus.ren_tag1     = '0;
    bus.fl_tag1      = '0;
    bus.fl_tag2      = '0;
    if (w_accept) begin
      bus.fl_alloc_cnt = w_nneed;
      bus.ren_tag0     = w_tag0;
      bus.ren_tag1     = w_tag1;
      if (bus.ren_need[0]) bus.ren_preg0 = bus.fl_preg1;
      if (bus.ren_need[1]) bus.ren_preg1 = bus.ren_need[0] ? bus.fl_preg2 : bus.fl_preg1;
      if (bus.ren_need[0])      bus.fl_tag1 = w_tag0;
      else if (bus.ren_need[1]) bus.fl_tag1 = w_tag1;
      if (bus.ren_need == 2'b11) bus.fl_tag2 = w_tag1;
    end
  end

  // Recovery FSM and speculative depth: a mispredict overrides the normal
  // accept/commit update of depth.
  always_comb begin
    state_d      = state_q;
    shoot_tag_d  = shoot_tag_q;
    w_commit_dec = bus.br_commit & (depth_q != '0);
    depth_d      = depth_q + (w_accept ? btag_t'(w_nbr) : '0) - btag_t'(w_commit_dec);
    // Only an older (smaller-tag) mispredict can restart an ongoing recovery.
    w_restart    = bus.mispredict_valid & (bus.mispredict_tag < shoot_tag_q);
    case (state_q)
      IDLE: begin
        if (bus.mispredict_valid) begin
          shoot_tag_d = bus.mispredict_tag;
          depth_d     = bus.mispredict_tag - btag_t'(1);
          state_d     = SHOOT;
        end
      end
      SHOOT, SETTLE: begin
        state_d = (state_q == SHOOT) ? SETTLE : IDLE;
        if (w_restart) begin
          shoot_tag_d = bus.mispredict_tag;
          depth_d     = bus.mispredict_tag - btag_t'(1);
          state_d     = SHOOT;
        end
      end
      default: state_d = IDLE;
    endcase
    bus.fl_shootdown = (state_q == SHOOT);
    bus.fl_shoot_tag = (state_q == SHOOT) ? shoot_tag_q : '0;
    bus.busy         = (state_q != IDLE);
    bus.depth        = depth_q;
  end

  // State, depth and latched shootdown tag registers; reset abandons recovery.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      shoot_tag_q <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      shoot_tag_q <= shoot_tag_d;
    end
  end

  // Frees are held off during SHOOT so they never coincide with the shootdown.
  freelist_ctrl_free_queue #(
    .DEPTH (FREE_Q_DEPTH)
  ) u_free_queue (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (bus.ret_valid),
    .push_preg0_i (bus.ret_preg0),
    .push_preg1_i (bus.ret_preg1),
    .push_ready_o (bus.ret_ready),
    .pop_en_i     (state_q != SHOOT),
    .free1_o      (bus.fl_free1),
    .free2_o      (bus.fl_free2),
    .free1_addr_o (bus.fl_free1_addr),
    .free2_addr_o (bus.fl_free2_addr)
  );

endmodule
`default_nettype wire

// File: doc/freelist_ctrl.md
Name: freelist_ctrl

Overview:
- Sequencing controller in front of the physical-register freelist.
- Accepts 2-wide rename groups with a valid/ready handshake and maps per-slot destination requests onto the freelist's first/second free pregs.
- Tracks speculative branch depth to generate per-allocation branch tags.
- Runs mispredict recovery (shootdown) and buffers retire-time frees so that frees never coincide with a shootdown update.

Parameters:
NUM_PREGS, 64, physical register count; PREG_W = $clog2(NUM_PREGS)
MAX_PREDICT_DEPTH, 4, max outstanding unresolved branches; TAG_W = $clog2(MAX_PREDICT_DEPTH+1)
FREE_Q_DEPTH, 4, retire-free buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ren_valid  in  1  rename group valid
ren_ready  out  1  group accepted when valid&ready
ren_need  in  2  bit s: slot s needs a destination preg
ren_br  in  2  bit s: slot s is a branch
ren_preg0 / ren_preg1  out  PREG_W  preg assigned to slot 0/1; valid on the accept cycle
ren_tag0 / ren_tag1  out  TAG_W  branch tag of slot 0/1
fl_num_free  in  PREG_W+1  freelist free count
fl_preg1 / fl_preg2  in  PREG_W  freelist first/second free preg
fl_alloc_cnt  out  2  pregs to pull this cycle (0..2)
fl_tag1 / fl_tag2  out  TAG_W  tags for the fl_preg1/fl_preg2 allocations
fl_shootdown  out  1  shootdown strobe
fl_shoot_tag  out  TAG_W  shootdown tag
fl_free1 / fl_free2  out  1  free strobes
fl_free1_addr / fl_free2_addr  out  PREG_W  pregs to free
mispredict_valid  in  1  branch mispredicted
mispredict_tag  in  TAG_W  tag of the instructions following it, 1..MAX_PREDICT_DEPTH
br_commit  in  1  oldest branch resolved correctly
ret_valid  in  2  per-slot retire free request
ret_preg0 / ret_preg1  in  PREG_W  stale pregs to free
ret_ready  out  1  retire frees accepted when 1
depth  out  TAG_W  current speculative depth
busy  out  1  recovery in progress

Behaviour:
- Reset: state IDLE, depth 0, free queue empty. All outputs 0 except ren_ready and ret_ready, which follow their equations. A reset during recovery abandons it.
- Tags: tag 0 means non-speculative. slot0 tag = depth; slot1 tag = depth + ren_br[0].
- nbr = popcount(ren_br); nneed = popcount(ren_need).
- ren_ready = (state==IDLE) & !mispredict_valid & (nneed <= fl_num_free) & (depth + nbr <= MAX_PREDICT_DEPTH).
- Accept cycle:
  - fl_alloc_cnt = nneed.
  - Slot 0 (if it needs a preg) takes fl_preg1. Slot 1 takes fl_preg1 if slot 0 does not need one, otherwise fl_preg2.
  - fl_tag1/fl_tag2 carry the tag of the consuming slot.
  - Combinational, zero latency. fl_alloc_cnt = 0 whenever no accept occurs.
- depth_next = depth + (accept ? nbr : 0) - (br_commit & depth != 0). br_commit with depth 0 is ignored.
- br_commit and mispredict_valid in the same cycle is illegal; the bench asserts it never occurs.
- FSM:
  - IDLE: on mispredict_valid, latch tag T, set depth <= T-1, go to SHOOT.
  - SHOOT (1 cycle): fl_shootdown = 1, fl_shoot_tag = T; no alloc; no free pops. Go to SETTLE.
  - SETTLE (1 cycle): no alloc, because fl_num_free is updating; frees allowed. Go to IDLE.
  - mispredict_valid in SHOOT/SETTLE with tag < T: latch the new tag, set depth <= tag-1, go to SHOOT. Tag >= T is ignored.
  - busy = (state != IDLE).
- Free queue:
  - FREE_Q_DEPTH-entry circular FIFO; pointers wrap modulo depth.
  - ret_ready = (free entries >= 2). On handshake, push ret_preg0 then ret_preg1, per ret_valid bit, order preserved.
  - Pop up to 2 per cycle except in SHOOT: head -> free1, next -> free2.
  - Registered outputs: minimum 1-cycle latency from ret to fl_free; no bypass.
  - Simultaneous push and pop in one cycle are legal; occupancy = occ + pushes - pops.
  - Empty queue: no strobes. Full queue: ret_ready = 0.

Decomposition:
- Shared package holds NUM_PREGS, MAX_PREDICT_DEPTH, PREG_W, TAG_W, preg_t, btag_t, and the FSM enum {IDLE, SHOOT, SETTLE}.
- One natural sub-module: free_queue, a 2-in/2-out circular FIFO with count.

Test Plan:
1. Reset, fl_num_free=64, fl_preg1=63, fl_preg2=62, ren_need=2'b11, ren_br=0 -> ready=1, ren_preg0=63, ren_preg1=62, fl_alloc_cnt=2, tags 0/0.
2. ren_need=2'b10, ren_br=2'b01, depth=1 -> ren_preg1=fl_preg1, ren_tag1=2, fl_tag1=2, depth becomes 2. With depth=3 and ren_br=2'b11 under MAX=4 -> ren_ready=0.
3. fl_num_free=1, ren_need=2'b11 -> ren_ready=0, fl_alloc_cnt=0. fl_num_free=1, ren_need=2'b01 -> accepted.
4. depth=3, mispredict tag 2 -> next cycle fl_shootdown=1, fl_shoot_tag=2, no free strobes; then SETTLE; then IDLE with depth=1. ren_ready=0 for 3 cycles.
5. Mispredict tag 3, then tag 1 while in SETTLE -> restart SHOOT with fl_shoot_tag=1; final depth 0.
6. Queue with 3 entries: push 2 while a SHOOT blocks pops -> ret_ready=0 until pops. Order preserved: frees emerge FIFO, 2 per cycle after SETTLE starts.
